// File: rtl/risc_ctrl_pkg.sv
// Shared encodings for the 8-bit RISC core: opcode values, sequencer states
// and the ALU-opcode classification used by the IR decode, ALU and bench.
package risc_ctrl_pkg;

  localparam int OP_W    = 3;
  localparam int STATE_W = 4;

  typedef enum logic [OP_W-1:0] {
    OP_HLT = 3'd0,
    OP_SKZ = 3'd1,
    OP_ADD = 3'd2,
    OP_AND = 3'd3,
    OP_XOR = 3'd4,
    OP_LDA = 3'd5,
    OP_STO = 3'd6,
    OP_JMP = 3'd7
  } opcode_t;

  typedef enum logic [STATE_W-1:0] {
    S0     = 4'd0,
    S1     = 4'd1,
    S2     = 4'd2,
    S3     = 4'd3,
    S4     = 4'd4,
    S5     = 4'd5,
    S6     = 4'd6,
    S7     = 4'd7,
    HALTED = 4'd8
  } state_t;

  // Opcodes whose operand is read from memory and routed through the ALU.
  function automatic logic is_aluop(input opcode_t op);
    return (op == OP_ADD) || (op == OP_AND) || (op == OP_XOR) || (op == OP_LDA);
  endfunction

endpackage

// File: rtl/risc_seq_ctrl.sv
// Fetch/execute sequencer of the 8-bit RISC core: 8-state cycle plus HALTED,
// decoded into PC/IR/ACC/bus/memory strobes. Optional macro RISC_SEQ_RESUME_EN.
module risc_seq_ctrl #(
  parameter int OP_W        = 3,
  parameter bit HALT_STICKY = 1'b1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            ena,
`ifdef RISC_SEQ_RESUME_EN
  input  logic            resume,
`endif
  input  logic [OP_W-1:0] opcode,
  input  logic            zero,
  output logic            inc_pc,
  output logic            load_pc,
  output logic            load_ir,
  output logic            load_acc,
  output logic            rd,
  output logic            wr,
  output logic            datactl_ena,
  output logic            halt,
  output logic [3:0]      state_o
);
  import risc_ctrl_pkg::*;

  state_t  state_reg;
  state_t  state_next;
  opcode_t op;
  logic    alu_op;

  assign op      = opcode_t'(opcode);
  assign alu_op  = is_aluop(op);
  assign state_o = state_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= S0;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = S0;
    case (state_reg)
      HALTED: begin
`ifdef RISC_SEQ_RESUME_EN
        state_next = resume ? S0 : HALTED;
`else
        state_next = HALTED;
`endif
      end
      S0, S1, S2, S4, S5, S6: begin
        if (ena) state_next = state_t'(state_reg + 4'd1);
      end
      S3: begin
        if (ena) state_next = (HALT_STICKY && op == OP_HLT) ? HALTED : S4;
      end
      default: state_next = S0;  // S7 wraps; illegal encodings recover to S0
    endcase
  end

  // Strobe decode; HALTED ignores ena, every other state is gated by it.
  always_comb begin
    inc_pc      = 1'b0;
    load_pc     = 1'b0;
    load_ir     = 1'b0;
    load_acc    = 1'b0;
    rd          = 1'b0;
    wr          = 1'b0;
    datactl_ena = 1'b0;
    halt        = 1'b0;
    if (!reset) begin
      if (state_reg == HALTED) begin
        halt = 1'b1;
      end else if (ena) begin
        case (state_reg)
          S0: begin
            rd      = 1'b1;
            load_ir = 1'b1;
          end
          S1: begin
            rd      = 1'b1;
            load_ir = 1'b1;
            inc_pc  = 1'b1;
          end
          S3: begin
            inc_pc = 1'b1;
            halt   = (op == OP_HLT);
          end
          S4: begin
            rd          = alu_op;
            load_pc     = (op == OP_JMP);
            datactl_ena = (op == OP_STO);
          end
          S5: begin
            rd          = alu_op;
            load_acc    = alu_op;
            load_pc     = (op == OP_JMP);
            inc_pc      = (op == OP_JMP) || (op == OP_SKZ && zero);
            datactl_ena = (op == OP_STO);
          end
          S6: begin
            rd          = alu_op;
            wr          = (op == OP_STO);
            datactl_ena = (op == OP_STO);
          end
          S7: begin
            inc_pc = (op == OP_SKZ) && zero;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_risc_seq_ctrl.sv
// Scoreboard bench for risc_seq_ctrl: directed instruction sequences push
// hand-computed state/strobe expectations; a negedge monitor pops and checks.
module tb_risc_seq_ctrl;
  import risc_ctrl_pkg::*;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       ena = 1'b0;
  logic       resume = 1'b0;
  logic [2:0] opcode = 3'd0;
  logic       zero = 1'b0;
  logic       inc_pc, load_pc, load_ir, load_acc, rd, wr, datactl_ena, halt;
  logic [3:0] state_o;

  always #5 clk = ~clk;

  risc_seq_ctrl dut (
    .clk         (clk),
    .reset       (reset),
    .ena         (ena),
`ifdef RISC_SEQ_RESUME_EN
    .resume      (resume),
`endif
    .opcode      (opcode),
    .zero        (zero),
    .inc_pc      (inc_pc),
    .load_pc     (load_pc),
    .load_ir     (load_ir),
    .load_acc    (load_acc),
    .rd          (rd),
    .wr          (wr),
    .datactl_ena (datactl_ena),
    .halt        (halt),
    .state_o     (state_o)
  );

  // Strobe vector: {inc_pc, load_pc, load_ir, load_acc, rd, wr, datactl_ena, halt}
  typedef struct packed {
    logic [3:0] st;
    logic [7:0] strb;
  } exp_t;

  exp_t q[$];
  int   n_cmp  = 0;
  int   n_fail = 0;
  int   n_cyc  = 0;

  // Hand-derived strobe tables, S0..S7, ena=1.
  localparam int R_ALU = 0, R_STO = 1, R_SKZ1 = 2, R_SKZ0 = 3, R_JMP = 4;
  logic [7:0] tbl [5][8] = '{
    '{8'h28, 8'hA8, 8'h00, 8'h80, 8'h08, 8'h18, 8'h08, 8'h00},  // ADD/AND/XOR/LDA
    '{8'h28, 8'hA8, 8'h00, 8'h80, 8'h02, 8'h02, 8'h06, 8'h00},  // STO
    '{8'h28, 8'hA8, 8'h00, 8'h80, 8'h00, 8'h80, 8'h00, 8'h80},  // SKZ zero=1
    '{8'h28, 8'hA8, 8'h00, 8'h80, 8'h00, 8'h00, 8'h00, 8'h00},  // SKZ zero=0
    '{8'h28, 8'hA8, 8'h00, 8'h80, 8'h40, 8'hC0, 8'h00, 8'h00}   // JMP
  };

  always @(negedge clk) begin
    exp_t       e;
    logic [7:0] act;
    if (q.size() > 0) begin
      e   = q.pop_front();
      act = {inc_pc, load_pc, load_ir, load_acc, rd, wr, datactl_ena, halt};
      n_cmp++;
      if (state_o !== e.st || act !== e.strb) begin
        n_fail++;
        $display("FAIL cyc%0d: state=%0d strobes=%h, required state=%0d strobes=%h",
                 n_cyc, state_o, act, e.st, e.strb);
      end else begin
        $display("cyc%0d ok: state=%0d strobes=%h", n_cyc, state_o, act);
      end
      n_cmp++;
      if (rd && wr) begin
        n_fail++;
        $display("FAIL rd_wr_excl cyc%0d: rd=%b wr=%b, required not both", n_cyc, rd, wr);
      end
    end
  end

  // Entered #1 after a posedge; drives one cycle and expects the listed outputs.
  task automatic step(input logic r, input logic en, input logic [2:0] op,
                      input logic z, input logic rs, input logic [3:0] st,
                      input logic [7:0] strb);
    reset  = r;
    ena    = en;
    opcode = op;
    zero   = z;
    resume = rs;
    q.push_back('{st: st, strb: strb});
    @(posedge clk);
    #1;
    n_cyc++;
  endtask

  task automatic run_instr(input logic [2:0] op, input logic z, input int row);
    for (int s = 0; s < 8; s++) step(1'b0, 1'b1, op, z, 1'b0, 4'(s), tbl[row][s]);
  endtask

  task automatic hlt_enter();
    for (int s = 0; s < 3; s++) step(1'b0, 1'b1, OP_HLT, 1'b0, 1'b0, 4'(s), tbl[R_ALU][s]);
    step(1'b0, 1'b1, OP_HLT, 1'b0, 1'b0, 4'd3, 8'h81);
  endtask

  initial begin
    // First reset cycle leaves the state register undefined; check from the second.
    @(posedge clk);
    #1;
    step(1'b1, 1'b0, OP_ADD, 1'b0, 1'b0, 4'd0, 8'h00);

    run_instr(OP_ADD, 1'b0, R_ALU);
    run_instr(OP_STO, 1'b0, R_STO);
    run_instr(OP_SKZ, 1'b1, R_SKZ1);
    run_instr(OP_SKZ, 1'b0, R_SKZ0);
    run_instr(OP_JMP, 1'b0, R_JMP);
    run_instr(OP_AND, 1'b1, R_ALU);
    run_instr(OP_XOR, 1'b0, R_ALU);
    run_instr(OP_LDA, 1'b0, R_ALU);
    run_instr(OP_STO, 1'b1, R_STO);
    run_instr(OP_JMP, 1'b1, R_JMP);

    // Reset in S5 of ADD: strobes killed during reset, state back to S0.
    for (int s = 0; s < 5; s++) step(1'b0, 1'b1, OP_ADD, 1'b0, 1'b0, 4'(s), tbl[R_ALU][s]);
    step(1'b1, 1'b1, OP_ADD, 1'b0, 1'b0, 4'd5, 8'h00);
    run_instr(OP_ADD, 1'b0, R_ALU);

    // ena dropped in S4 of STO: strobes 0, state returns to S0.
    for (int s = 0; s < 4; s++) step(1'b0, 1'b1, OP_STO, 1'b0, 1'b0, 4'(s), tbl[R_STO][s]);
    step(1'b0, 1'b0, OP_STO, 1'b0, 1'b0, 4'd4, 8'h00);
    step(1'b0, 1'b0, OP_STO, 1'b0, 1'b0, 4'd0, 8'h00);
    run_instr(OP_STO, 1'b0, R_STO);

    // Sticky HLT: HALTED held for 20 cycles with ena toggling, left only by reset.
    hlt_enter();
    for (int i = 0; i < 20; i++)
      step(1'b0, 1'(i % 2), OP_ADD, 1'b0, 1'b0, 4'd8, 8'h01);
    step(1'b1, 1'b1, OP_ADD, 1'b0, 1'b0, 4'd8, 8'h00);
    run_instr(OP_ADD, 1'b0, R_ALU);

`ifdef RISC_SEQ_RESUME_EN
    hlt_enter();
    step(1'b0, 1'b0, OP_HLT, 1'b0, 1'b0, 4'd8, 8'h01);
    step(1'b0, 1'b0, OP_HLT, 1'b0, 1'b1, 4'd8, 8'h01);
    run_instr(OP_ADD, 1'b0, R_ALU);
`endif

    // Drain the scoreboard with a bounded wait.
    for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge clk);
    n_cmp++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d entries left, required 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
